host_arbiter: RTL and testbench



---
 rtl/host_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/host_arbiter.sv | 145 ++++++++++++++
 tb/tb_host_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/host_arb_pkg.sv
// Shared types and helpers for the host request/response arbiter.
package host_arb_pkg;

  localparam int HOST_DW = 64;

  typedef logic [HOST_DW-1:0] host_word_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import host_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = IW'(idx);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/host_arbiter.sv
// Shares one host request/response channel among NCORES cores: round-robin request
// stage with per-core outstanding limits, and a one-entry routed response stage.
module host_arbiter
  import host_arb_pkg::*;
#(
  parameter  int NCORES  = 2,
  parameter  int MAX_OUT = 2,
  localparam int IDW     = id_width(NCORES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCORES-1:0]         core_req_valid,
  output logic [NCORES-1:0]         core_req_ready,
  input  logic [NCORES*HOST_DW-1:0] core_req,
  output logic [NCORES-1:0]         core_resp_valid,
  input  logic [NCORES-1:0]         core_resp_ready,
  output host_word_t                core_resp,
  output logic                      host_req_valid,
  input  logic                      host_req_ready,
  output logic [IDW-1:0]            host_req_id,
  output host_word_t                host_req,
  input  logic                      host_resp_valid,
  output logic                      host_resp_ready,
  input  logic [IDW-1:0]            host_resp_id,
  input  host_word_t                host_resp,
  output logic                      err_bad_id
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0]     cnt [NCORES];
  logic [IDW-1:0]    rr_ptr;
  logic [NCORES-1:0] elig, gnt, inc, dec;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any, free;
  host_word_t        sel_word;

  logic              req_vld_p1;
  logic [IDW-1:0]    req_id_p1;
  host_word_t        req_word_p1;
  logic              rsp_vld_p1;
  logic [IDW-1:0]    rsp_id_p1;
  host_word_t        rsp_word_p1;
  logic              err_p1;
  logic              rsp_hs, rsp_bad, rsp_drain;

  assign free = !req_vld_p1 || host_req_ready;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCORES; i++)
      elig[i] = core_req_valid[i] && (int'(cnt[i]) < MAX_OUT);
  end

  rr_arbiter #(.N(NCORES)) u_rr (
    .req     (elig),
    .en      (free && !rst),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign core_req_ready = gnt;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NCORES; i++)
      if (gnt[i]) sel_word = core_req[i*HOST_DW +: HOST_DW];
  end

  // ---- request stage p1: granted word held until the host takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_p1  <= 1'b0;
      req_id_p1   <= '0;
      req_word_p1 <= '0;
      rr_ptr      <= '0;
    end else if (free) begin
      req_vld_p1 <= gnt_any;
      if (gnt_any) begin
        req_id_p1   <= gnt_idx;
        req_word_p1 <= sel_word;
        rr_ptr      <= (int'(gnt_idx) == NCORES - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign host_req_valid = req_vld_p1;
  assign host_req_id    = req_id_p1;
  assign host_req       = req_word_p1;

  // ---- response stage p1: one entry, routed by id
  always_comb begin
    core_resp_valid = '0;
    if (rsp_vld_p1) core_resp_valid[rsp_id_p1] = 1'b1;
  end

  assign rsp_drain       = rsp_vld_p1 && core_resp_ready[rsp_id_p1];
  assign host_resp_ready = !rst && (!rsp_vld_p1 || core_resp_ready[rsp_id_p1]);
  assign rsp_hs          = host_resp_valid && host_resp_ready;
  assign rsp_bad         = int'(host_resp_id) >= NCORES;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_p1  <= 1'b0;
      rsp_id_p1   <= '0;
      rsp_word_p1 <= '0;
      err_p1      <= 1'b0;
    end else begin
      err_p1 <= rsp_hs && rsp_bad;
      if (rsp_hs && !rsp_bad) begin
        rsp_vld_p1  <= 1'b1;
        rsp_id_p1   <= host_resp_id;
        rsp_word_p1 <= host_resp;
      end else if (rsp_drain) begin
        rsp_vld_p1 <= 1'b0;
      end
    end
  end

  assign core_resp  = rsp_word_p1;
  assign err_bad_id = err_p1;

  // ---- outstanding counters: grant adds one, delivered response removes one
  assign inc = core_req_valid & core_req_ready;
  assign dec = core_resp_valid & core_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCORES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_cnt_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(dec[g] && !inc[g] && cnt[g] == '0));
  end

endmodule

// File: tb/tb_host_arbiter.sv
// Randomized and directed bench for host_arbiter against a queue-based reference model.
module tb_host_arbiter;

  localparam int NC = 3;
  localparam int MO = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     core_req_valid = '0, core_req_ready;
  logic [NC*64-1:0]  core_req = '0;
  logic [NC-1:0]     core_resp_valid, core_resp_ready = '0;
  logic [63:0]       core_resp, host_req, host_resp = '0;
  logic              host_req_valid, host_req_ready = 1'b0;
  logic              host_resp_valid = 1'b0, host_resp_ready, err_bad_id;
  logic [1:0]        host_req_id, host_resp_id = '0;

  always #5 clk = ~clk;

  host_arbiter #(.NCORES(NC), .MAX_OUT(MO)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req        (core_req),
    .core_resp_valid (core_resp_valid),
    .core_resp_ready (core_resp_ready),
    .core_resp       (core_resp),
    .host_req_valid  (host_req_valid),
    .host_req_ready  (host_req_ready),
    .host_req_id     (host_req_id),
    .host_req        (host_req),
    .host_resp_valid (host_resp_valid),
    .host_resp_ready (host_resp_ready),
    .host_resp_id    (host_resp_id),
    .host_resp       (host_resp),
    .err_bad_id      (err_bad_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: state of the held request, held response, pointer and counts.
  int          m_ptr = 0, m_hid = 0, m_rsid = 0;
  int          m_cnt [NC] = '{default: 0};
  bit          m_hv = 0, m_rsv = 0, m_err = 0;
  logic [63:0] m_hw = '0, m_rsw = '0;
  int          hq [$];
  int          gcnt [NC] = '{default: 0};

  // hmode: 0 = host silent, 1 = host answers oldest accepted request, 2 = host sends bad id
  task automatic step(input bit r, input logic [NC-1:0] crv, input bit hrr,
                      input logic [NC-1:0] crr, input int hmode);
    int          g;
    bit          free, hs_rsp, bad, e_hrr;
    logic [NC-1:0] e_crr, e_crv;
    logic [63:0] w [NC];
    @(posedge clk); #1;
    rst             = r;
    core_req_valid  = crv;
    host_req_ready  = hrr;
    core_resp_ready = crr;
    for (int i = 0; i < NC; i++) begin
      w[i] = {$urandom, $urandom};
      core_req[i*64 +: 64] = w[i];
    end
    host_resp = {$urandom, $urandom};
    bad = (hmode == 2);
    if (hmode == 1 && hq.size() > 0) begin
      host_resp_valid = 1'b1;
      host_resp_id    = 2'(hq[0]);
    end else if (bad) begin
      host_resp_valid = 1'b1;
      host_resp_id    = 2'd3;
    end else begin
      host_resp_valid = 1'b0;
      host_resp_id    = 2'($urandom_range(0, NC - 1));
    end
    @(negedge clk);
    free = !m_hv || hrr;
    g = -1;
    if (!r && free)
      for (int k = 0; k < NC; k++) begin
        int idx = (m_ptr + k) % NC;
        if (g < 0 && crv[idx] && m_cnt[idx] < MO) g = idx;
      end
    e_crr = '0;
    if (g >= 0) e_crr[g] = 1'b1;
    e_crv = '0;
    if (m_rsv) e_crv[m_rsid] = 1'b1;
    e_hrr = !r && (!m_rsv || crr[m_rsid]);
    chk("core_req_ready", 64'(core_req_ready), 64'(e_crr));
    chk("host_resp_ready", 64'(host_resp_ready), 64'(e_hrr));
    chk("core_resp_valid", 64'(core_resp_valid), 64'(e_crv));
    chk("host_req_valid", 64'(host_req_valid), 64'(m_hv));
    chk("err_bad_id", 64'(err_bad_id), 64'(m_err));
    if (m_hv) begin
      chk("host_req", host_req, m_hw);
      chk("host_req_id", 64'(host_req_id), 64'(m_hid));
    end
    if (m_rsv) chk("core_resp", core_resp, m_rsw);
    for (int i = 0; i < NC; i++) if (core_req_ready[i] === 1'b1) gcnt[i]++;
    hs_rsp = host_resp_valid && e_hrr;
    if (r) begin
      m_ptr = 0; m_hv = 0; m_hw = '0; m_hid = 0;
      m_rsv = 0; m_rsw = '0; m_rsid = 0; m_err = 0;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      hq.delete();
    end else begin
      if (m_hv && hrr) hq.push_back(m_hid);
      for (int i = 0; i < NC; i++)
        m_cnt[i] = m_cnt[i] + int'(g == i) - int'(e_crv[i] && crr[i]);
      if (g >= 0) begin
        m_hv = 1; m_hw = w[g]; m_hid = g; m_ptr = (g + 1) % NC;
      end else if (free) begin
        m_hv = 0;
      end
      m_err = hs_rsp && bad;
      if (hs_rsp && !bad) begin
        m_rsv = 1; m_rsid = int'(host_resp_id); m_rsw = host_resp;
        void'(hq.pop_front());
      end else if (m_rsv && crr[m_rsid]) begin
        m_rsv = 0;
      end
    end
  endtask

  initial begin
    int total;
    step(1, '0, 0, '0, 0);
    step(1, '0, 0, '0, 0);
    chk("rst_host_req", host_req, 64'd0);
    chk("rst_host_req_id", 64'(host_req_id), 64'd0);
    chk("rst_core_resp", core_resp, 64'd0);

    // single request round trip on core 0
    step(0, 3'b001, 1, '1, 0);
    step(0, 3'b000, 1, '1, 1);
    step(0, 3'b000, 1, '1, 1);
    step(0, 3'b000, 1, '1, 0);

    // host backpressure with all cores requesting, then release
    step(0, 3'b111, 1, '1, 0);
    repeat (5) step(0, 3'b111, 0, '1, 0);
    step(0, 3'b111, 1, '1, 0);

    // outstanding limit on core 0, core 1 still served, then one response frees core 0
    step(1, '0, 0, '0, 0);
    repeat (3) step(0, 3'b001, 1, '1, 0);
    step(0, 3'b011, 1, '1, 0);
    repeat (4) step(0, 3'b011, 1, '1, 1);

    // response stall on core 1 while host keeps offering, then release
    step(1, '0, 0, '0, 0);
    step(0, 3'b010, 1, '1, 0);
    step(0, 3'b010, 1, 3'b101, 0);
    repeat (4) step(0, 3'b010, 1, 3'b101, 1);
    repeat (3) step(0, 3'b000, 1, 3'b111, 1);

    // bad id drop, then reset with the request register full
    step(0, 3'b000, 1, '1, 2);
    step(0, 3'b000, 1, '1, 0);
    step(0, 3'b100, 0, '1, 0);
    step(1, 3'b111, 0, '1, 0);
    step(0, 3'b111, 0, '1, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int hm;
      hm = $urandom_range(0, 99);
      step(($urandom_range(0, 199) == 0),
           3'($urandom),
           ($urandom_range(0, 3) != 0),
           {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)},
           (hm < 3) ? 2 : (hm < 63) ? 1 : 0);
    end

    // fairness: all cores always requesting, host always ready and answering
    step(1, '0, 0, '0, 0);
    for (int i = 0; i < NC; i++) gcnt[i] = 0;
    total = 0;
    for (int c = 0; c < 400 && total < 99; c++) begin
      step(0, '1, 1, '1, 1);
      total = gcnt[0] + gcnt[1] + gcnt[2];
    end
    for (int i = 0; i < NC; i++) chk($sformatf("fair_core%0d", i), 64'(gcnt[i]), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
